// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, canonical NOP,
// default instruction memory depth and the fetch FSM state set.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  // The instruction memory is sized from this value as well.
  localparam int IMEM_DEPTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_LOAD  = 2'd1,
    FS_RUN   = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_t;

  // A fetch address is usable only if it is word aligned and inside the memory.
  function automatic logic pcLegal(input logic [XLEN-1:0] pc, input int depth);
    return (pc[1:0] == 2'b00) && ({2'b00, pc[XLEN-1:2]} < 32'(depth));
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle around the fetch controller: decode output stage,
// boot loader write channel and the instruction memory port.
// The loader address carries one extra bit so that out-of-range
// beats are visible to the controller instead of aliasing into memory.
interface fetch_ctrl_if #(
  parameter int ADDR_W    = 5,
  parameter int LD_ADDR_W = ADDR_W + 1
);
  import riscv_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [XLEN-1:0]      instr;
  logic [XLEN-1:0]      instr_pc;

  logic                 ld_valid;
  logic                 ld_ready;
  logic [LD_ADDR_W-1:0] ld_addr;
  logic [XLEN-1:0]      ld_data;
  logic                 ld_last;
  logic                 ld_err;

  logic [ADDR_W-1:0]    imem_addr;
  logic [XLEN-1:0]      imem_rdata;
  logic                 imem_we;
  logic [XLEN-1:0]      imem_wdata;

  modport master (
    output instr_valid, instr, instr_pc,
    output ld_ready, ld_err,
    output imem_addr, imem_we, imem_wdata,
    input  instr_ready,
    input  ld_valid, ld_addr, ld_data, ld_last,
    input  imem_rdata
  );

  modport slave (
    input  instr_valid, instr, instr_pc,
    input  ld_ready, ld_err,
    input  imem_addr, imem_we, imem_wdata,
    output instr_ready,
    output ld_valid, ld_addr, ld_data, ld_last,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output register between fetch and decode.
// A load captures a new word; a flush drops whatever is held.
// With neither, the held word stays stable for decode.
module fetch_out_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // Capture a fetched word, or drop the held one on flush; reset shows a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= INSTR_NOP;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, sequences combinational-read fetches
// into the decode output stage, takes redirects from execute and
// lends the instruction memory write port to the boot loader while parked.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int              ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_halt,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_fault,
  fetch_ctrl_if.master    bus
);

  localparam logic [1:0] S_IDLE  = FS_IDLE;
  localparam logic [1:0] S_LOAD  = FS_LOAD;
  localparam logic [1:0] S_RUN   = FS_RUN;
  localparam logic [1:0] S_FAULT = FS_FAULT;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;
  logic            r_ldErr;

  logic [XLEN-1:0] w_fetchPc;
  logic            w_illegal;
  logic            w_fetching;
  logic            w_fire;
  logic            w_haltNow;
  logic            w_ldBeat;
  logic            w_ldInRange;
  logic            w_outValid;
  logic [XLEN-1:0] w_outInstr;
  logic [XLEN-1:0] w_outPc;

  // A redirect overrides the sequential PC for this cycle's fetch.
  assign w_fetchPc   = i_redirect_valid ? i_redirect_pc : r_pc;
  assign w_illegal   = !pcLegal(w_fetchPc, IMEM_DEPTH);
  assign w_fetching  = (r_state == S_RUN) || (r_state == S_FAULT);

  // In RUN a fetch fires on redirect, or when the output slot is free or being drained
  // and no halt is pending; in FAULT only a redirect can fire a fetch.
  assign w_fire      = ((r_state == S_RUN) &&
                        (i_redirect_valid ||
                         (!i_halt && (!w_outValid || bus.instr_ready)))) ||
                       ((r_state == S_FAULT) && i_redirect_valid);
  assign w_haltNow   = (r_state == S_RUN) && !i_redirect_valid && i_halt;

  assign w_ldBeat    = (r_state == S_LOAD) && bus.ld_valid;
  assign w_ldInRange = 32'(bus.ld_addr) < 32'(IMEM_DEPTH);

  // Memory port: the loader owns it in LOAD, fetch owns it otherwise.
  always_comb begin
    bus.imem_addr = r_pc[ADDR_W+1:2];
    if (w_ldBeat) begin
      bus.imem_addr = bus.ld_addr[ADDR_W-1:0];
    end else if (w_fetching) begin
      bus.imem_addr = w_fetchPc[ADDR_W+1:2];
    end
  end

  assign bus.imem_we    = w_ldBeat && w_ldInRange;
  assign bus.imem_wdata = bus.ld_data;
  assign bus.ld_ready   = (r_state == S_LOAD);
  assign bus.ld_err     = r_ldErr;
  assign o_fault        = r_fault;

  // FSM, PC, fault flag and sticky loader error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_ldErr <= 1'b0;
    end else begin
      if (w_ldBeat && !w_ldInRange) begin
        r_ldErr <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_redirect_valid) begin
            r_pc <= i_redirect_pc;
          end
          if (bus.ld_valid) begin
            r_state <= S_LOAD;
          end else if (i_start) begin
            r_state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (bus.ld_valid && bus.ld_last) begin
            r_state <= S_IDLE;
          end
        end
        S_RUN, S_FAULT: begin
          if (w_fire) begin
            if (w_illegal) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_pc    <= w_fetchPc;
            end else begin
              r_state <= S_RUN;
              r_fault <= 1'b0;
              r_pc    <= w_fetchPc + 32'd4;
            end
          end else if (w_haltNow) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fetch_out_reg u_outReg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_fire && !w_illegal),
    .i_flush (w_haltNow || (w_fire && w_illegal)),
    .i_instr (bus.imem_rdata),
    .i_pc    (w_fetchPc),
    .o_valid (w_outValid),
    .o_instr (w_outInstr),
    .o_pc    (w_outPc)
  );

  assign bus.instr_valid = w_outValid;
  assign bus.instr       = w_outInstr;
  assign bus.instr_pc    = w_outPc;

endmodule
